io_pattern_gen: RTL and testbench
=================================

# io_pattern_gen

Programmable IO pattern transmitter that drives a single line with a stored sequence of (level, duration) entries. Durations are counted in bit periods set by a clock-enable divider. Its entry format and programming port match the IO trigger matcher, so a sequence written for the matcher can be replayed to emulate a target, or used to exercise the matcher in loopback. It sits beside the trigger logic and is programmed over the same register bus.

## Interface
- stateaddr_width, 6, entry RAM address width
- stateaddr_states, 64, number of entry RAM words
- clk  in  1  system clock
- rst  in  1  synchronous, active-high reset
- start  in  1  one-cycle request to begin playback from address 0
- idle_level  in  1  level driven on tx_line when not playing
- clkdivider  in  18  bit period = clkdivider+1 clk cycles
- state_prog_en  in  1  RAM address taken from state_prog_addr
- state_prog_addr  in  stateaddr_width  programming address
- state_prog_wr  in  1  write strobe, qualified by state_prog_en
- state_prog_data  in  18  entry: [17]=level, [16:9]=reserved (write 0), [8:0]=duration in bit periods
- tx_line  out  1  pattern output
- tx_oe  out  1  high while playing, so the pad can tristate when idle
- busy  out  1  playback in progress
- done  out  1  one-cycle pulse at normal end of playback
- entry_strobe  out  1  one-cycle pulse at the start of each played entry
- cur_addr  out  stateaddr_width  address of the entry currently on tx_line

## Operation
- Entry RAM: single port, synchronous write, registered read address (1-cycle read latency). Address mux uses state_prog_addr when state_prog_en=1, otherwise the internal pointer.
- End marker: an entry equal to 18'h3FFFF ends playback. It is not played.
- Duration 0 is played as 1 bit period.
- FSM states:
  - IDLE: tx_line=idle_level, tx_oe=0, busy=0. start=1 with state_prog_en=0 goes to FETCH with pointer=0. start is ignored while state_prog_en=1.
  - FETCH: two cycles, covering the address issue and the data-valid cycle. If the data is the end marker, go to FINISH. Otherwise load level and duration, then go to PLAY.
  - PLAY: tx_line=level. The bit-period counter counts 0..clkdivider and gives one tick per period. The duration counter decrements on each tick.
    - The next entry is prefetched during PLAY (pointer+1), so the next level appears on the clock edge after the last tick, with no gap cycles.
    - On the last tick, if the prefetched word is the end marker, or the pointer is stateaddr_states-1, go to FINISH. The pointer does not wrap.
  - FINISH: one cycle. done=1, tx_line=idle_level, tx_oe=0, then go to IDLE.
- start while busy is ignored.
- state_prog_en=1 while busy aborts playback: return to IDLE the next cycle with tx_line=idle_level and no done pulse.
- clkdivider and idle_level are sampled continuously. Changing clkdivider mid-entry takes effect at the next counter wrap.
- Reset values: tx_line=idle_level, tx_oe=0, busy=0, done=0, entry_strobe=0, cur_addr=0, pointer=0, FSM=IDLE.

## Timing
- start sampled at edge N.
- busy=1 from edge N+1.
- Entry 0's level appears on tx_line, with tx_oe=1 and entry_strobe=1, at edge N+3. The bit-period counter is cleared at that same edge.
- Each entry holds for max(duration,1)*(clkdivider+1) clk cycles.
- Following entries begin exactly at the end of the previous one, with entry_strobe pulsing on that edge.
- After the last entry's final cycle, the next edge asserts done=1, sets tx_line=idle_level, tx_oe=0 and busy=0. busy drops on the same edge as the done pulse.
- End marker at address 0: done pulses at edge N+3 and tx_line never leaves idle_level.
- A new start is accepted on the cycle after done.
- rst mid-playback: all outputs take their reset values on the next edge. No done pulse.

## Test plan
- Basic playback: clkdivider=1. Program {1,3}, {0,2}, marker, idle_level=0. Pulse start → tx_line high for 6 clk starting at N+3, then low for 4 clk. done at N+13; busy high over N+1..N+12. entry_strobe at N+3 and N+9.
- Empty sequence and zero duration:
  - Marker at address 0 → done at N+3, tx_oe stays 0.
  - Entry {1,0} → high for clkdivider+1 cycles.
- Full RAM: 64 entries, no marker, each {i[0],1}, clkdivider=0 → 64 alternating cycles, then done. cur_addr stops at 63 with no wrap.
- Long period: clkdivider=18'h3FFFF, duration 511 → entry length exactly 511*262144 cycles (shorten via force on the counter if required).
- Ignored start and abort:
  - start re-pulsed mid-play → no restart.
  - state_prog_en raised mid-play → tx_line=idle_level next cycle, no done.
  - rst mid-play → reset values next edge.
- Loopback: feed tx_line into the trigger matcher with the same entries and matching clkdivider settings → trig_out asserts once per playback.

Source files
------------

// File: rtl/io_pattern_gen_if.sv
// rtl/io_pattern_gen_if.sv - playback control, entry programming and line outputs of the IO pattern generator
interface io_pattern_gen_if #(
  parameter int stateaddr_width = 6
);
  logic                       start;
  logic                       idle_level;
  logic [17:0]                clkdivider;
  logic                       state_prog_en;
  logic [stateaddr_width-1:0] state_prog_addr;
  logic                       state_prog_wr;
  logic [17:0]                state_prog_data;
  logic                       tx_line;
  logic                       tx_oe;
  logic                       busy;
  logic                       done;
  logic                       entry_strobe;
  logic [stateaddr_width-1:0] cur_addr;

  modport master (
    output start, idle_level, clkdivider,
    output state_prog_en, state_prog_addr, state_prog_wr, state_prog_data,
    input  tx_line, tx_oe, busy, done, entry_strobe, cur_addr
  );

  modport slave (
    input  start, idle_level, clkdivider,
    input  state_prog_en, state_prog_addr, state_prog_wr, state_prog_data,
    output tx_line, tx_oe, busy, done, entry_strobe, cur_addr
  );
endinterface

// File: rtl/io_pattern_gen.sv
// rtl/io_pattern_gen.sv - replays stored (level, duration) entries onto a single IO line
module io_pattern_gen #(
  parameter int stateaddr_width  = 6,
  parameter int stateaddr_states = 64
) (
  input  logic              clk,
  input  logic              rst,
  io_pattern_gen_if.slave   bus
);
  localparam logic [17:0]                END_MARKER = 18'h3FFFF;
  localparam logic [stateaddr_width-1:0] LAST_ADDR  = stateaddr_width'(stateaddr_states - 1);
  localparam logic [stateaddr_width-1:0] ADDR_ONE   = stateaddr_width'(1);

  typedef enum logic [2:0] {S_IDLE, S_FETCH0, S_FETCH1, S_PLAY, S_FINISH} state_t;

  logic [17:0]                ram_q [stateaddr_states];
  logic [stateaddr_width-1:0] raddr_q, raddr_d;
  state_t                     state_q, state_d;
  logic                       start_q;
  logic [stateaddr_width-1:0] ptr_q, ptr_d;
  logic [stateaddr_width-1:0] cur_q, cur_d;
  logic                       level_q, level_d;
  logic [8:0]                 rem_q, rem_d;
  logic [17:0]                bit_q, bit_d;
  logic [17:0]                div_q, div_d;
  logic                       strobe_q, strobe_d;
  logic                       load;
  logic [stateaddr_width-1:0] load_ptr;

  logic [17:0] rdata;
  logic        is_marker;
  logic        tick;
  logic        last_tick;

  assign rdata     = ram_q[raddr_q];
  assign is_marker = (rdata == END_MARKER);
  assign tick      = (bit_q == div_q);
  assign last_tick = tick && (rem_q <= 9'd1);

  always_ff @(posedge clk) begin
    if (bus.state_prog_en && bus.state_prog_wr) begin
      ram_q[bus.state_prog_addr] <= bus.state_prog_data;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= S_IDLE;
      start_q  <= 1'b0;
      raddr_q  <= '0;
      ptr_q    <= '0;
      cur_q    <= '0;
      level_q  <= 1'b0;
      rem_q    <= '0;
      bit_q    <= '0;
      div_q    <= '0;
      strobe_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      start_q  <= bus.start & ~bus.state_prog_en;
      raddr_q  <= raddr_d;
      ptr_q    <= ptr_d;
      cur_q    <= cur_d;
      level_q  <= level_d;
      rem_q    <= rem_d;
      bit_q    <= bit_d;
      div_q    <= div_d;
      strobe_q <= strobe_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    ptr_d    = ptr_q;
    cur_d    = cur_q;
    level_d  = level_q;
    rem_d    = rem_q;
    bit_d    = bit_q;
    div_d    = div_q;
    strobe_d = 1'b0;
    load     = 1'b0;
    load_ptr = ptr_q;

    case (state_q)
      S_IDLE: begin
        if (start_q && !bus.state_prog_en) begin
          state_d = S_FETCH0;
          ptr_d   = '0;
        end
      end
      S_FETCH0: state_d = S_FETCH1;
      S_FETCH1: begin
        if (is_marker) begin
          state_d = S_FINISH;
        end else begin
          load     = 1'b1;
          load_ptr = ptr_q;
        end
      end
      S_PLAY: begin
        // rdata already holds entry ptr+1, prefetched while this one plays
        if (tick) begin
          bit_d = '0;
          div_d = bus.clkdivider;
          if (last_tick) begin
            if (is_marker || ptr_q == LAST_ADDR) begin
              state_d = S_FINISH;
            end else begin
              load     = 1'b1;
              load_ptr = ptr_q + ADDR_ONE;
            end
          end else begin
            rem_d = rem_q - 9'd1;
          end
        end else begin
          bit_d = bit_q + 18'd1;
        end
      end
      S_FINISH: state_d = S_IDLE;
      default:  state_d = S_IDLE;
    endcase

    if (load) begin
      state_d  = S_PLAY;
      ptr_d    = load_ptr;
      cur_d    = load_ptr;
      level_d  = rdata[17];
      rem_d    = (rdata[8:0] == 9'd0) ? 9'd1 : rdata[8:0];
      bit_d    = '0;
      div_d    = bus.clkdivider;
      strobe_d = 1'b1;
    end

    if (bus.state_prog_en && state_q != S_IDLE) begin
      state_d  = S_IDLE;
      strobe_d = 1'b0;
    end

    // read address is the entry needed one cycle after state_d takes effect
    if (bus.state_prog_en) begin
      raddr_d = bus.state_prog_addr;
    end else if (state_d == S_PLAY) begin
      raddr_d = ptr_d + ADDR_ONE;
    end else begin
      raddr_d = ptr_d;
    end
  end

  assign bus.tx_oe        = (state_q == S_PLAY);
  assign bus.tx_line      = (state_q == S_PLAY) ? level_q : bus.idle_level;
  assign bus.busy         = (state_q == S_FETCH0) || (state_q == S_FETCH1) || (state_q == S_PLAY);
  assign bus.done         = (state_q == S_FINISH);
  assign bus.entry_strobe = strobe_q;
  assign bus.cur_addr     = cur_q;
endmodule

// File: tb/tb_io_pattern_gen.sv
// tb/tb_io_pattern_gen.sv - vector table, randomized playback against a waveform model, and abort/reset sequences
module tb_io_pattern_gen;
  localparam logic [17:0] MARK = 18'h3FFFF;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  io_pattern_gen_if #(.stateaddr_width(6)) bus();
  io_pattern_gen #(.stateaddr_width(6), .stateaddr_states(64)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  typedef struct packed {
    logic       tx;
    logic       oe;
    logic       busy;
    logic       done;
    logic       strobe;
    logic [5:0] addr;
  } obs_t;

  typedef struct {
    int          div;
    logic        idle;
    logic [17:0] e0, e1, e2;
    int          exp_done;
    int          exp_busy;
    int          exp_oe;
    int          exp_high;
    int          exp_strobe;
  } vec_t;

  int          n_checks = 0;
  int          n_pass = 0;
  logic [17:0] mem_m [64];
  logic [5:0]  cur_m = '0;
  obs_t        exp_q [$];
  vec_t        vecs [4];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_checks++;
    if (act === req) n_pass++;
    else $display("FAIL %s: got %0h, required %0h", name, act, req);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [17:0] ent(input logic l, input int d);
    return {l, 8'h00, d[8:0]};
  endfunction

  function automatic obs_t mk(input logic tx, input logic oe, input logic busy, input logic done,
                              input logic strobe, input logic [5:0] addr);
    obs_t o;
    o.tx = tx; o.oe = oe; o.busy = busy; o.done = done; o.strobe = strobe; o.addr = addr;
    return o;
  endfunction

  function automatic obs_t sample();
    return mk(bus.tx_line, bus.tx_oe, bus.busy, bus.done, bus.entry_strobe, bus.cur_addr);
  endfunction

  task automatic prog(input int a, input logic [17:0] d);
    bus.state_prog_en   = 1'b1;
    bus.state_prog_wr   = 1'b1;
    bus.state_prog_addr = a[5:0];
    bus.state_prog_data = d;
    step();
    bus.state_prog_en = 1'b0;
    bus.state_prog_wr = 1'b0;
    mem_m[a] = d;
  endtask

  // Expected per-cycle outputs from the start-sampling edge onwards, one entry per edge
  function automatic void build_exp(input logic idle, input int div);
    logic [5:0] last;
    int         d;
    int         len;
    last = cur_m;
    exp_q.delete();
    exp_q.push_back(mk(idle, 1'b0, 1'b0, 1'b0, 1'b0, last));
    exp_q.push_back(mk(idle, 1'b0, 1'b1, 1'b0, 1'b0, last));
    exp_q.push_back(mk(idle, 1'b0, 1'b1, 1'b0, 1'b0, last));
    for (int k = 0; k < 64; k++) begin
      if (mem_m[k] == MARK) break;
      d   = int'(mem_m[k][8:0]);
      len = ((d == 0) ? 1 : d) * (div + 1);
      last = k[5:0];
      for (int c = 0; c < len; c++)
        exp_q.push_back(mk(mem_m[k][17], 1'b1, 1'b1, 1'b0, c == 0, last));
    end
    exp_q.push_back(mk(idle, 1'b0, 1'b0, 1'b1, 1'b0, last));
    exp_q.push_back(mk(idle, 1'b0, 1'b0, 1'b0, 1'b0, last));
    cur_m = last;
  endfunction

  task automatic play_check(input string name, input logic idle, input int div, input int repulse_at);
    obs_t got;
    int   n_bad;
    int   first_bad;
    obs_t bad_got;
    obs_t bad_exp;
    bus.idle_level = idle;
    bus.clkdivider = div[17:0];
    build_exp(idle, div);
    n_bad = 0; first_bad = -1; bad_got = '0; bad_exp = '0;
    bus.start = 1'b1;
    step();
    bus.start = 1'b0;
    for (int i = 0; i < exp_q.size(); i++) begin
      if (i > 0) begin
        bus.start = (i == repulse_at);
        step();
        bus.start = 1'b0;
      end
      got = sample();
      if (got !== exp_q[i]) begin
        if (first_bad < 0) begin
          first_bad = i; bad_got = got; bad_exp = exp_q[i];
        end
        n_bad++;
      end
    end
    check($sformatf("%s bad-cycles (first at N+%0d got %h want %h)", name, first_bad, bad_got, bad_exp),
          n_bad, 0);
  endtask

  initial begin
    int done_at, busy_n, oe_n, high_n, strobe_n, stray_n, cnt;

    bus.start = 1'b0; bus.idle_level = 1'b1; bus.clkdivider = '0;
    bus.state_prog_en = 1'b0; bus.state_prog_addr = '0; bus.state_prog_wr = 1'b0; bus.state_prog_data = '0;
    for (int k = 0; k < 64; k++) mem_m[k] = MARK;
    rst = 1'b1;
    step(); step();
    check("reset tx_line", bus.tx_line, 1);
    check("reset tx_oe", bus.tx_oe, 0);
    check("reset busy", bus.busy, 0);
    check("reset done", bus.done, 0);
    check("reset entry_strobe", bus.entry_strobe, 0);
    check("reset cur_addr", bus.cur_addr, 0);
    rst = 1'b0;
    step();

    vecs[0] = '{1, 1'b0, ent(1, 3), ent(0, 2), MARK, 13, 12, 10, 6, 2};
    vecs[1] = '{1, 1'b1, MARK, MARK, MARK, 3, 2, 0, 0, 0};
    vecs[2] = '{2, 1'b0, ent(1, 0), MARK, MARK, 6, 5, 3, 3, 1};
    vecs[3] = '{0, 1'b1, ent(0, 4), ent(1, 0), MARK, 8, 7, 5, 1, 2};
    for (int v = 0; v < 4; v++) begin
      prog(0, vecs[v].e0); prog(1, vecs[v].e1); prog(2, vecs[v].e2);
      build_exp(vecs[v].idle, vecs[v].div);
      bus.idle_level = vecs[v].idle;
      bus.clkdivider = vecs[v].div[17:0];
      bus.start = 1'b1;
      step();
      bus.start = 1'b0;
      done_at = -1; busy_n = 0; oe_n = 0; high_n = 0; strobe_n = 0; stray_n = 0;
      for (int off = 0; off < 60; off++) begin
        if (off > 0) step();
        if (bus.done && done_at < 0) done_at = off;
        if (bus.busy) busy_n++;
        if (bus.tx_oe) oe_n++;
        if (bus.tx_oe && bus.tx_line) high_n++;
        if (!bus.tx_oe && bus.tx_line !== vecs[v].idle) stray_n++;
        if (bus.entry_strobe) strobe_n++;
      end
      check($sformatf("vec%0d done edge", v), done_at, vecs[v].exp_done);
      check($sformatf("vec%0d busy cycles", v), busy_n, vecs[v].exp_busy);
      check($sformatf("vec%0d oe cycles", v), oe_n, vecs[v].exp_oe);
      check($sformatf("vec%0d high cycles", v), high_n, vecs[v].exp_high);
      check($sformatf("vec%0d strobes", v), strobe_n, vecs[v].exp_strobe);
      check($sformatf("vec%0d idle level off-play", v), stray_n, 0);
    end

    for (int r = 0; r < 12; r++) begin
      cnt = $urandom_range(1, 6);
      for (int k = 0; k < cnt; k++) prog(k, ent($urandom_range(0, 1) == 1, $urandom_range(0, 4)));
      prog(cnt, MARK);
      play_check($sformatf("random%0d", r), $urandom_range(0, 1) == 1, $urandom_range(0, 3), -1);
    end

    for (int k = 0; k < 64; k++) prog(k, ent(k[0], 1));
    play_check("full ram", 1'b0, 0, -1);
    check("full ram cur_addr stop", bus.cur_addr, 63);

    prog(0, ent(1, 3)); prog(1, ent(0, 2)); prog(2, MARK);
    play_check("restart ignored", 1'b0, 1, 5);
    play_check("back to back", 1'b1, 2, -1);

    prog(0, ent(1, 300)); prog(1, MARK);
    play_check("long period", 1'b0, 99, -1);

    prog(0, ent(1, 3)); prog(1, ent(0, 2)); prog(2, MARK);
    bus.idle_level = 1'b0; bus.clkdivider = 18'd1;
    bus.start = 1'b1; step(); bus.start = 1'b0;
    for (int i = 0; i < 5; i++) step();
    check("abort pre tx_oe", bus.tx_oe, 1);
    bus.state_prog_en = 1'b1;
    step();
    bus.state_prog_en = 1'b0;
    check("abort tx_line", bus.tx_line, 0);
    check("abort tx_oe", bus.tx_oe, 0);
    check("abort busy", bus.busy, 0);
    cnt = 0;
    for (int i = 0; i < 20; i++) begin
      step();
      if (bus.done || bus.busy) cnt++;
    end
    check("abort no done", cnt, 0);
    cur_m = 6'd0;

    bus.start = 1'b1; step(); bus.start = 1'b0;
    for (int i = 0; i < 10; i++) step();
    check("pre-rst cur_addr", bus.cur_addr, 1);
    rst = 1'b1;
    step();
    rst = 1'b0;
    check("rst mid-play tx_line", bus.tx_line, 0);
    check("rst mid-play outputs", {bus.tx_oe, bus.busy, bus.done, bus.entry_strobe, bus.cur_addr}, 0);
    cnt = 0;
    for (int i = 0; i < 20; i++) begin
      step();
      if (bus.done || bus.busy) cnt++;
    end
    check("rst no done", cnt, 0);
    cur_m = 6'd0;

    bus.state_prog_en = 1'b1; bus.start = 1'b1;
    step();
    bus.state_prog_en = 1'b0; bus.start = 1'b0;
    cnt = 0;
    for (int i = 0; i < 6; i++) begin
      step();
      if (bus.busy) cnt++;
    end
    check("start ignored while prog_en", cnt, 0);
    play_check("after ignored start", 1'b1, 0, -1);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
